// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write counters gating decode issue.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle retire satisfy a consumer.
module issue_scoreboard #(
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [31:0]            id_instruction,
    input  logic                   wb_valid,
    input  logic [31:0]            wb_instruction,
    output logic                   stall,
    output logic                   issue,
    output logic [6:0]             pending_total,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // {writes, dest}
    function automatic logic [5:0] dest_of(input logic [31:0] ins);
        logic       wr;
        logic [4:0] d;
        wr = 1'b0;
        d  = ins[20:16];
        case (ins[31:26])
            6'b000000: begin
                d = ins[15:11];
                case (ins[5:0])
                    6'b100000, 6'b100001, 6'b100010,
                    6'b100011, 6'b100110: wr = 1'b1;
                    default:              wr = 1'b0;
                endcase
            end
            6'b100011, 6'b001111, 6'b001000: wr = 1'b1;
            default: wr = 1'b0;
        endcase
        return {wr, d};
    endfunction

    // {uses rs, uses rt}
    function automatic logic [1:0] srcs_of(input logic [31:0] ins);
        logic [1:0] s;
        case (ins[31:26])
            6'b100011, 6'b001000: s = 2'b10;
            6'b001111, 6'b000010: s = 2'b00;
            default:              s = 2'b11;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt [32];

    logic       id_wr, wb_wr, use_rs, use_rt;
    logic [4:0] id_dest, wb_dest, rs, rt;
    logic       retire, alloc, same, inc, dec, under;
    logic       rs_busy, rt_busy, src_stall, full;
    logic [CNT_W-1:0] rs_cnt, rt_cnt, dest_cnt, wb_cnt;

    assign {id_wr, id_dest} = dest_of(id_instruction);
    assign {wb_wr, wb_dest} = dest_of(wb_instruction);
    assign {use_rs, use_rt} = srcs_of(id_instruction);
    assign rs = id_instruction[25:21];
    assign rt = id_instruction[20:16];

    // Hazard evaluation and allocate/retire decisions for this cycle
    always_comb begin
        rs_cnt   = cnt[rs];
        rt_cnt   = cnt[rt];
        dest_cnt = cnt[id_dest];
        wb_cnt   = cnt[wb_dest];
        retire   = wb_valid && wb_wr && (wb_dest != 5'd0);
`ifdef SCOREBOARD_WB_BYPASS_EN
        rs_busy = (rs_cnt != '0) &&
                  !(retire && wb_dest == rs && rs_cnt == CNT_ONE);
        rt_busy = (rt_cnt != '0) &&
                  !(retire && wb_dest == rt && rt_cnt == CNT_ONE);
`else
        rs_busy = (rs_cnt != '0);
        rt_busy = (rt_cnt != '0);
`endif
        src_stall = (use_rs && rs != 5'd0 && rs_busy) ||
                    (use_rt && rt != 5'd0 && rt_busy);
        full  = id_wr && id_dest != 5'd0 && dest_cnt == CNT_MAX &&
                !(retire && wb_dest == id_dest);
        stall = id_valid && (src_stall || full);
        issue = id_valid && !stall;
        alloc = issue && id_wr && id_dest != 5'd0;
        same  = alloc && retire && id_dest == wb_dest;
        inc   = alloc && !same;
        dec   = retire && !same && wb_cnt != '0;
        under = retire && wb_cnt == '0;
    end

    // Per-register pending counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            if (inc) cnt[id_dest] <= dest_cnt + CNT_ONE;
            if (dec) cnt[wb_dest] <= wb_cnt - CNT_ONE;
        end
    end

    // Running total, stall statistics and sticky underflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_total <= '0;
            stall_count   <= '0;
            underflow_err <= 1'b0;
        end else begin
            pending_total <= pending_total + 7'(inc) - 7'(dec);
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (under)
                underflow_err <= 1'b1;
        end
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line:
- CNT_W, 2, width of each per-register pending-write counter.
- STALL_CNT_W, 16, width of the stall-cycle statistics counter.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  a decode-stage instruction is presented.
- id_instruction  in  32  decode-stage instruction word.
- wb_valid  in  1  a writeback-stage instruction is presented.
- wb_instruction  in  32  writeback-stage instruction word.
- stall  out  1  hold decode; the instruction must not issue this cycle.
- issue  out  1  id_valid & ~stall.
- pending_total  out  7  number of outstanding register writes across all registers.
- stall_count  out  STALL_CNT_W  saturating count of cycles with stall=1.
- underflow_err  out  1  sticky: a writeback retired a register with count 0.

Function
REQ-003 Opcodes SHALL be decoded from [31:26]; for op 000000, funct [5:0].
REQ-004 Writers SHALL be:
- op 000000 with funct add 100000, addu 100001, sub 100010, subu 100011, xor 100110: dest = [15:11].
- lw 100011, lui 001111, addi 001000: dest = [20:16].
REQ-005 Sources SHALL be:
- op 000000, sw 101011, beq 000100, bne 000101: rs [25:21] and rt [20:16].
- addi, lw: rs only.
- lui, j 000010: none.
- Any other opcode: rs and rt.
REQ-006 Register 0 SHALL never be counted as a dest or checked as a source.
REQ-007 Each of registers 1..31 SHALL hold a CNT_W-bit pending count.
REQ-008 Retire SHALL occur when wb_valid=1 and wb_instruction is a writer with dest!=0; the count of dest decrements by 1 at the next edge.
REQ-009 Allocate SHALL occur when issue=1 and id_instruction is a writer with dest!=0; the count of dest increments by 1 at the next edge.
REQ-010 When allocate and retire target the same register in the same cycle, its count SHALL be unchanged.
REQ-011 stall SHALL be combinational: id_valid=1 and (any source has an effective count >0, or the dest count equals 2^CNT_W-1 with no same-cycle retire of that dest).
REQ-012 The effective count SHALL be defined by CONFIG (REQ-018/019).
REQ-013 A retire on a register whose count is 0 SHALL leave the count at 0 and set underflow_err at the next edge.
REQ-014 pending_total SHALL equal the registered sum of all counts, updated at the same edge as the counts.
REQ-015 stall_count SHALL increment on each edge where stall=1 and SHALL hold at all-ones.
REQ-016 With id_valid=0: stall=0 and issue=0, and no allocate occurs.

Reset
REQ-017 When rst=1 at an edge:
- All counts, pending_total, stall_count and underflow_err SHALL become 0.
- Allocates and retires presented in that cycle SHALL be discarded.
- stall and issue SHALL evaluate from the zeroed state on the following cycle.

Configuration
REQ-018 With macro SCOREBOARD_WB_BYPASS_EN defined, the effective count SHALL be count minus 1 when a retire targets that register in the same cycle. The register file writes before it reads on the same edge, so the consumer issues in the retire cycle.
REQ-019 Without SCOREBOARD_WB_BYPASS_EN, the effective count SHALL be the raw count, so the consumer issues one cycle after the retire. Ports are identical in both builds.

Verification
REQ-020 Reset, then id addi r5 (0x20050004) valid for 1 cycle -> issue=1, stall=0; next cycle count[5]=1 and pending_total=1.
REQ-021 Issue add r3,r1,r2 (0x00221820), then present sub r4,r3,r1 (0x00612022) -> stall=1 until the r3 retire. With BYPASS: issue in the retire cycle. Without BYPASS: issue one cycle later. stall_count equals the stalled cycles.
REQ-022 Issue lui r7 three times with no retire -> a fourth lui r7 stalls (count=3, CNT_W=2). A retire of r7 in the same cycle lets it issue with count staying 3.
REQ-023 Retire lw r9 with count[9]=0 -> count stays 0, underflow_err=1 and remains 1 until rst.
REQ-024 Pending count 2 on r6, assert rst with id_valid=1 and a writer of r6 -> next cycle all counts=0, pending_total=0, and no allocate from the reset cycle.
REQ-025 Present j (0x08000010) or sw r0,0(r0) (0xAC000000) while r0 is written -> stall=0.
